// File: rtl/heap_store_mp.sv
// rtl/heap_store_mp.sv - three-port heap node store with parent addressing, atomic swap and size counter
module heap_store_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] lm_din,
    input  logic [ADDR_W-1:0] lm_addr,
    input  logic              lm_we,
    output logic [DATA_W-1:0] lm_dout,
    input  logic [DATA_W-1:0] rm_din,
    input  logic [ADDR_W-1:0] rm_addr,
    input  logic              rm_we,
    output logic [DATA_W-1:0] rm_dout,
    input  logic [DATA_W-1:0] nl_din,
    input  logic [ADDR_W-1:0] nl_addr,
    input  logic              nl_we,
    input  logic              nl_branch,
    output logic [DATA_W-1:0] nl_dout,
    input  logic              swap_req,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    output logic              swap_busy,
    output logic              swap_done,
    input  logic              size_inc,
    input  logic              size_dec,
    output logic [ADDR_W:0]   heap_size
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } swap_state_t;

    swap_state_t       state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] sw_a;
    logic [ADDR_W-1:0] sw_b;
    logic [DATA_W-1:0] sw_va;
    logic [DATA_W-1:0] sw_vb;

    logic [ADDR_W-1:0] eff_nl;
    logic              ports_open;
    logic              lm_wr;
    logic              rm_wr;
    logic              nl_wr;
    logic [DATA_W-1:0] lm_rd;
    logic [DATA_W-1:0] rm_rd;
    logic [DATA_W-1:0] nl_rd;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Root is its own parent, so address 0 never wraps in branch mode.
    always_comb begin
        eff_nl = nl_addr;
        if (nl_branch && (nl_addr != '0)) begin
            eff_nl = (nl_addr - ADDR_W'(1)) >> 1;
        end
    end

    assign ports_open = (state == S_IDLE);
    assign lm_wr      = ports_open && lm_we && in_range(lm_addr);
    assign rm_wr      = ports_open && rm_we && in_range(rm_addr);
    assign nl_wr      = ports_open && nl_we && in_range(eff_nl);

    // Write-first bypass: the winning write of this cycle overrides the array.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (!in_range(a)) begin
            return '0;
        end else if (nl_wr && (eff_nl == a)) begin
            return nl_din;
        end else if (lm_wr && (lm_addr == a)) begin
            return lm_din;
        end else if (rm_wr && (rm_addr == a)) begin
            return rm_din;
        end else begin
            return mem[a];
        end
    endfunction

    always_comb begin
        lm_rd = read_port(lm_addr);
        rm_rd = read_port(rm_addr);
        nl_rd = read_port(eff_nl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lm_dout <= '0;
            rm_dout <= '0;
            nl_dout <= '0;
        end else begin
            lm_dout <= lm_rd;
            rm_dout <= rm_rd;
            nl_dout <= nl_rd;
        end
    end

    // Later assignments win, giving nl > lm > rm on a shared address.
    always_ff @(posedge clk) begin
        if (rm_wr) begin
            mem[rm_addr] <= rm_din;
        end
        if (lm_wr) begin
            mem[lm_addr] <= lm_din;
        end
        if (nl_wr) begin
            mem[eff_nl] <= nl_din;
        end
        if ((state == S_WR) && !rst) begin
            if (in_range(sw_a)) begin
                mem[sw_a] <= sw_vb;
            end
            if (in_range(sw_b)) begin
                mem[sw_b] <= sw_va;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            swap_busy <= 1'b0;
            swap_done <= 1'b0;
            sw_a      <= '0;
            sw_b      <= '0;
            sw_va     <= '0;
            sw_vb     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    swap_done <= 1'b0;
                    if (swap_req) begin
                        sw_a      <= swap_a;
                        sw_b      <= swap_b;
                        swap_busy <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_RD: begin
                    sw_va     <= in_range(sw_a) ? mem[sw_a] : '0;
                    sw_vb     <= in_range(sw_b) ? mem[sw_b] : '0;
                    swap_done <= 1'b1;
                    state     <= S_WR;
                end
                S_WR: begin
                    swap_busy <= 1'b0;
                    swap_done <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    swap_busy <= 1'b0;
                    swap_done <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            heap_size <= '0;
        end else if (size_inc && !size_dec && (heap_size != DEPTH_L)) begin
            heap_size <= heap_size + 1'b1;
        end else if (size_dec && !size_inc && (heap_size != '0)) begin
            heap_size <= heap_size - 1'b1;
        end
    end

endmodule

// File: tb/tb_heap_store_mp.sv
// tb/tb_heap_store_mp.sv - scoreboard bench for heap_store_mp against a cycle-level reference model
module tb_heap_store_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] lm_din, rm_din, nl_din;
    logic [AW-1:0] lm_addr, rm_addr, nl_addr;
    logic          lm_we, rm_we, nl_we, nl_branch;
    logic [DW-1:0] lm_dout, rm_dout, nl_dout;
    logic          swap_req;
    logic [AW-1:0] swap_a, swap_b;
    logic          swap_busy, swap_done;
    logic          size_inc, size_dec;
    logic [AW:0]   heap_size;

    always #5 clk = ~clk;

    heap_store_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .lm_din(lm_din), .lm_addr(lm_addr), .lm_we(lm_we), .lm_dout(lm_dout),
        .rm_din(rm_din), .rm_addr(rm_addr), .rm_we(rm_we), .rm_dout(rm_dout),
        .nl_din(nl_din), .nl_addr(nl_addr), .nl_we(nl_we), .nl_branch(nl_branch),
        .nl_dout(nl_dout),
        .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
        .swap_busy(swap_busy), .swap_done(swap_done),
        .size_inc(size_inc), .size_dec(size_dec), .heap_size(heap_size)
    );

    typedef struct {
        logic [DW-1:0] lm, rm, nl;
        bit            k_lm, k_rm, k_nl;
        bit            busy, done;
        int            size;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem_m [DEPTH];
    bit            known [DEPTH];
    int            cyc = 0;
    int            acc = -100;
    int            sa = 0, sb = 0;
    int            size_m = 0;

    function automatic bit busy_at(input int c);
        return ((c - acc) == 1) || ((c - acc) == 2);
    endfunction

    task automatic check(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, c, act, req);
        end
    endtask

    function automatic void predict(input int a, input bit wa, input int eff,
                                    output logic [DW-1:0] d, output bit k);
        if (wa && nl_we && (eff == a)) begin
            d = nl_din; k = 1'b1;
        end else if (wa && lm_we && (int'(lm_addr) == a)) begin
            d = lm_din; k = 1'b1;
        end else if (wa && rm_we && (int'(rm_addr) == a)) begin
            d = rm_din; k = 1'b1;
        end else begin
            d = mem_m[a]; k = known[a];
        end
    endfunction

    // One clock: predict next-cycle outputs from current inputs, advance model, push expectation.
    task automatic step();
        exp_t          e;
        bit            wa;
        int            eff;
        logic [DW-1:0] t;
        wa  = !busy_at(cyc) && !rst;
        eff = nl_branch ? ((nl_addr == 0) ? 0 : (int'(nl_addr) - 1) / 2) : int'(nl_addr);
        e.cyc = cyc + 1;
        if (rst) begin
            e.lm = '0; e.rm = '0; e.nl = '0;
            e.k_lm = 1'b1; e.k_rm = 1'b1; e.k_nl = 1'b1;
            acc    = -100;
            size_m = 0;
        end else begin
            predict(int'(lm_addr), wa, eff, e.lm, e.k_lm);
            predict(int'(rm_addr), wa, eff, e.rm, e.k_rm);
            predict(eff, wa, eff, e.nl, e.k_nl);
            if ((cyc - acc) == 2) begin
                t = mem_m[sa]; mem_m[sa] = mem_m[sb]; mem_m[sb] = t;
            end
            if (wa) begin
                if (rm_we) begin mem_m[rm_addr] = rm_din; known[rm_addr] = 1'b1; end
                if (lm_we) begin mem_m[lm_addr] = lm_din; known[lm_addr] = 1'b1; end
                if (nl_we) begin mem_m[eff] = nl_din; known[eff] = 1'b1; end
            end
            if (swap_req && !busy_at(cyc)) begin
                acc = cyc; sa = int'(swap_a); sb = int'(swap_b);
            end
            if (size_inc && !size_dec && size_m < DEPTH) size_m++;
            else if (size_dec && !size_inc && size_m > 0) size_m--;
        end
        e.busy = busy_at(cyc + 1);
        e.done = ((cyc + 1 - acc) == 2);
        e.size = size_m;
        @(posedge clk);
        q.push_back(e);
        cyc++;
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; lm_we = 1'b0; rm_we = 1'b0; nl_we = 1'b0; nl_branch = 1'b0;
        swap_req = 1'b0; size_inc = 1'b0; size_dec = 1'b0;
    endtask

    task automatic read_all(input int a);
        lm_addr = AW'(a); rm_addr = AW'(a); nl_addr = AW'(a); nl_branch = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.k_lm) check("lm_dout", e.cyc, lm_dout, e.lm);
                if (e.k_rm) check("rm_dout", e.cyc, rm_dout, e.rm);
                if (e.k_nl) check("nl_dout", e.cyc, nl_dout, e.nl);
                check("swap_busy", e.cyc, DW'(swap_busy), DW'(e.busy));
                check("swap_done", e.cyc, DW'(swap_done), DW'(e.done));
                check("heap_size", e.cyc, DW'(heap_size), DW'(e.size));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        quiet();
        lm_din = '0; rm_din = '0; nl_din = '0; swap_a = '0; swap_b = '0;
        read_all(0);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            read_all(i); lm_we = 1'b1; lm_din = $urandom; step();
        end
        quiet();

        // Registered read on all ports
        read_all(0); lm_addr = 5'd3; lm_we = 1'b1; lm_din = 32'hA5A5_0003; step();
        quiet(); read_all(3); step(); step();

        // Three-way collision with all ports reading the same address
        read_all(7); lm_we = 1'b1; rm_we = 1'b1; nl_we = 1'b1;
        nl_din = 32'h11; lm_din = 32'h22; rm_din = 32'h33; step();
        quiet(); read_all(7); step(); step();

        // Parent addressing
        nl_branch = 1'b1;
        nl_addr = 5'd6; step();
        nl_addr = 5'd5; step();
        nl_addr = 5'd0; step();
        nl_addr = 5'd4; nl_we = 1'b1; nl_din = 32'hBEEF_0001; step();
        quiet(); read_all(1); step(); step();

        // Swap of 1 and 4, with writes attempted while busy
        lm_addr = 5'd1; lm_we = 1'b1; lm_din = 32'd10;
        rm_addr = 5'd4; rm_we = 1'b1; rm_din = 32'd40; step();
        quiet(); lm_addr = 5'd1; rm_addr = 5'd4;
        swap_a = 5'd1; swap_b = 5'd4; swap_req = 1'b1; step();
        swap_req = 1'b0; lm_we = 1'b1; lm_din = 32'hDEAD; step(); step();
        lm_we = 1'b0; step(); step();
        swap_a = 5'd4; swap_b = 5'd4; swap_req = 1'b1; step();
        swap_req = 1'b0; step(); step(); step();

        // Reset one cycle into a swap, then a fresh swap
        swap_a = 5'd1; swap_b = 5'd4; swap_req = 1'b1; step();
        swap_req = 1'b0; rst = 1'b1; step();
        rst = 1'b0; step(); step();
        swap_req = 1'b1; step();
        swap_req = 1'b0; step(); step(); step();

        // Size counter saturation
        for (int i = 0; i < 33; i++) begin size_inc = 1'b1; step(); end
        size_dec = 1'b1; step();
        size_inc = 1'b0;
        for (int i = 0; i < 40; i++) step();
        quiet();

        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            lm_addr   = rand_addr(); rm_addr = rand_addr(); nl_addr = rand_addr();
            lm_din    = $urandom; rm_din = $urandom; nl_din = $urandom;
            lm_we     = !rst && $urandom_range(0, 1);
            rm_we     = !rst && $urandom_range(0, 1);
            nl_we     = !rst && $urandom_range(0, 1);
            nl_branch = $urandom_range(0, 1);
            swap_req  = ($urandom_range(0, 5) == 0);
            swap_a    = rand_addr(); swap_b = rand_addr();
            size_inc  = $urandom_range(0, 1);
            size_dec  = $urandom_range(0, 1);
            step();
        end
        quiet();
        for (int i = 0; i < 4; i++) step();

        @(negedge clk); @(negedge clk);
        check("scoreboard_drained", cyc, DW'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
